switcher: RTL and testbench



---
 rtl/switcher_pkg.sv | 27 ++
 rtl/switcher_prescaler.sv | 44 ++++
 rtl/switcher.sv | 83 ++++++++
 tb/tb_switcher.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/switcher_pkg.sv
// Shared constants, digit-index type and enable decode for the display scanner.
// Latency: n/a (package only).
// Backpressure: n/a (no handshakes in this path).
package switcher_pkg;

    localparam int NUM_DIGITS    = 4;
    localparam int DEFAULT_DIV   = 40000;
    localparam int DEFAULT_BLANK = 2;

    typedef logic [1:0] dig_idx_t;

    // One enable per digit, bit 0 = D1. 'lit' is false during the blank gap,
    // so every digit sits at its inactive level then.
    function automatic logic [NUM_DIGITS-1:0] digit_decode(
        input dig_idx_t idx,
        input logic     lit,
        input logic     active_low
    );
        logic [NUM_DIGITS-1:0] onehot;
        onehot = '0;
        if (lit) begin
            onehot[idx] = 1'b1;
        end
        return onehot ^ {NUM_DIGITS{active_low}};
    endfunction

endpackage

// File: rtl/switcher_prescaler.sv
// Slot counter: counts 0..DIV-1 and flags the last cycle of each digit slot.
// Latency: cnt_nxt and slot_end are combinational from the current count.
// Backpressure: none; 'en' simply freezes the count (held at 0 out of reset).
//
// Ports: clk, rst_n (async active-low), en (count enable),
//        cnt_nxt (count after this edge), slot_end (this edge closes the slot).
module switcher_prescaler
    import switcher_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic [$clog2(DIV)-1:0]  cnt_nxt,
    output logic                    slot_end
);

    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        slot_end = en && (cnt_q == LAST);
        cnt_d    = cnt_q;
        if (en) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The top registers its outputs from the next state, so it needs cnt_d.
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/switcher.sv
// Four-digit seven-segment scanner: rotates one digit enable per DIV-cycle slot.
// Latency: enables/sel are registered from the next-state decode (no comb path to pins).
// Backpressure: none; free-running whenever rst_n is high.
//
// Ports: clk, rst_n (async active-low), d1..d4 (digit enables, polarity set by
//        ACTIVE_LOW), sel (current digit index, 0 = d1, valid during blank too).
module switcher
    import switcher_pkg::*;
#(
    parameter int DIV        = DEFAULT_DIV,
    parameter int BLANK      = DEFAULT_BLANK,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        d1,
    output logic        d2,
    output logic        d3,
    output logic        d4,
    output logic [1:0]  sel
);

    localparam int CW = $clog2(DIV);

    // Enables seen while in reset: cnt = 0 and idx = 0, so D1 is lit only
    // when there is no blank gap.
    localparam logic [NUM_DIGITS-1:0] DIG_RST =
        digit_decode(2'd0, (BLANK == 0), ACTIVE_LOW);

    if ((DIV < 2) || (BLANK < 0) || (BLANK >= DIV)) begin : g_bad_params
        $fatal(1, "switcher: illegal parameters DIV=%0d BLANK=%0d", DIV, BLANK);
    end

    // Reset release is resynchronised: run_q is the first stage and the
    // counter/output registers it enables form the second, so the first
    // count happens on the second rising edge after rst_n rises.
    logic run_q;
    logic run_d;

    logic [CW-1:0]          cnt_nxt;
    logic                   slot_end;
    dig_idx_t               idx_q;
    dig_idx_t               idx_d;
    logic                   lit;
    logic [NUM_DIGITS-1:0]  dig_q;
    logic [NUM_DIGITS-1:0]  dig_d;

    switcher_prescaler #(
        .DIV      (DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_q),
        .cnt_nxt  (cnt_nxt),
        .slot_end (slot_end)
    );

    always_comb begin
        run_d = 1'b1;
        idx_d = slot_end ? idx_q + 2'd1 : idx_q;   // 3 wraps to 0 naturally
        lit   = (int'(cnt_nxt) >= BLANK);
        dig_d = digit_decode(idx_d, lit, ACTIVE_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            idx_q <= '0;
            dig_q <= DIG_RST;
        end else begin
            run_q <= run_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
        end
    end

    assign d1  = dig_q[0];
    assign d2  = dig_q[1];
    assign d3  = dig_q[2];
    assign d4  = dig_q[3];
    assign sel = idx_q;

endmodule

// File: tb/tb_switcher.sv
// Scoreboard bench for switcher: four configurations share one clock and reset.
// The driver advances an elapsed-time model and queues expected outputs; the
// monitor pops and compares at every falling edge.
module tb_switcher;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       a1, a2, a3, a4;  logic [1:0] a_sel;
    logic       b1, b2, b3, b4;  logic [1:0] b_sel;
    logic       c1, c2, c3, c4;  logic [1:0] c_sel;
    logic       e1, e2, e3, e4;  logic [1:0] e_sel;

    switcher #(.DIV(4),  .BLANK(1), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .d1(a1), .d2(a2), .d3(a3), .d4(a4), .sel(a_sel));
    switcher #(.DIV(2),  .BLANK(0), .ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .d1(b1), .d2(b2), .d3(b3), .d4(b4), .sel(b_sel));
    switcher #(.DIV(4),  .BLANK(1), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .d1(c1), .d2(c2), .d3(c3), .d4(c4), .sel(c_sel));
    switcher #(.DIV(40), .BLANK(2), .ACTIVE_LOW(1'b0)) u_e (
        .clk(clk), .rst_n(rst_n), .d1(e1), .d2(e2), .d3(e3), .d4(e4), .sel(e_sel));

    // {sel, d4, d3, d2, d1} per instance
    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] c;
        logic [5:0] e;
        logic       rst;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n     = 0;   // rising edges seen with rst_n high since last release

    // Reference: after t counting edges the scan is in slot t/div, position
    // t%div within it; digit = slot mod 4, lit once position reaches blank.
    function automatic logic [5:0] model(input int t, input int div, input int blank, input bit al);
        int         pos;
        int         dig;
        logic [3:0] o;
        pos = t % div;
        dig = (t / div) % 4;
        for (int k = 0; k < 4; k++) begin
            o[k] = ((pos >= blank) && (dig == k)) ^ al;
        end
        return {dig[1:0], o};
    endfunction

    function automatic exp_t expect_now(input int t, input logic r);
        exp_t x;
        x.a   = model(t, 4, 1, 1'b0);
        x.b   = model(t, 2, 0, 1'b0);
        x.c   = model(t, 4, 1, 1'b1);
        x.e   = model(t, 40, 2, 1'b0);
        x.rst = r;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got sel/d4..d1=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: optional async assert (mid-cycle, checked
    // immediately) or release, then queue what the outputs must show.
    task automatic step(input bit do_assert, input bit do_release);
        exp_t x;
        @(posedge clk);
        if (rst_n) n++;
        #2;
        if (do_assert) begin
            rst_n = 1'b0;
            n     = 0;
            #1;
            x = expect_now(0, 1'b1);
            cmp("async_rst_a", {a_sel, a4, a3, a2, a1}, x.a);
            cmp("async_rst_b", {b_sel, b4, b3, b2, b1}, x.b);
            cmp("async_rst_c", {c_sel, c4, c3, c2, c1}, x.c);
            cmp("async_rst_e", {e_sel, e4, e3, e2, e1}, x.e);
        end
        if (do_release) begin
            rst_n = 1'b1;
            n     = 0;
        end
        q.push_back(expect_now((n > 0) ? n - 1 : 0, !rst_n));
    endtask

    // Monitor: compare every sampled cycle; also track lit run lengths on u_e.
    int run_len [4];
    logic [3:0] e_prev = 4'b0;

    initial begin
        for (int k = 0; k < 4; k++) run_len[k] = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t x;
                logic [3:0] e_now;
                x = q.pop_front();
                cmp("dut_a", {a_sel, a4, a3, a2, a1}, x.a);
                cmp("dut_b", {b_sel, b4, b3, b2, b1}, x.b);
                cmp("dut_c", {c_sel, c4, c3, c2, c1}, x.c);
                cmp("dut_e", {e_sel, e4, e3, e2, e1}, x.e);
                e_now = {e4, e3, e2, e1};
                total++;
                if ($countones(e_now) > 1) begin
                    bad++;
                    $display("FAIL onehot_e got=%b required at most one set", e_now);
                end
                for (int k = 0; k < 4; k++) begin
                    if (x.rst) begin
                        run_len[k] = 0;
                    end else if (e_now[k]) begin
                        run_len[k]++;
                    end else if (e_prev[k]) begin
                        total++;
                        if (run_len[k] != 38) begin
                            bad++;
                            $display("FAIL runlen_e d%0d got=%0d required=38", k + 1, run_len[k]);
                        end
                        run_len[k] = 0;
                    end
                end
                e_prev = x.rst ? 4'b0 : e_now;
            end
        end
    end

    initial begin
        // Reset hold, 100 ns.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        // Full rotations on every instance (u_e needs 160 cycles per scan).
        for (int i = 0; i < 700; i++) step(1'b0, 1'b0);
        // Reset during u_a's D3 slot, then restart.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0);   // n = 9 -> t = 8, D3 blank
        step(1'b0, 1'b0);                               // t = 9, D3 lit
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
        // Randomised reset pulses and run lengths.
        for (int s = 0; s < 15; s++) begin
            int hold;
            int run;
            hold = $urandom_range(0, 4);
            run  = $urandom_range(3, 300);
            step(1'b1, 1'b0);
            for (int i = 0; i < hold; i++) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            for (int i = 0; i < run; i++) step(1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
